// File: rtl/inst_fetch_ctrl_if.sv
// Shared width defaults and the fetch-controller bus: imem port, redirect,
// fetch enable and the decode-side valid/ready handshake.
package inst_fetch_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

interface inst_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = inst_fetch_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = inst_fetch_ctrl_pkg::DATA_WIDTH
);
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_inst;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  misalign_err;

  modport master (
    input  fetch_en, imem_inst, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_inst, out_pc, misalign_err
  );
  modport slave (
    output fetch_en, imem_inst, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_inst, out_pc, misalign_err
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing against a 1-cycle-latency imem,
// a single-entry skid buffer for decode backpressure, and redirect squash.
module inst_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = inst_fetch_ctrl_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = inst_fetch_ctrl_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  skid_full_q, skid_full_d;
  logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                  misalign_q, misalign_d;
  logic                  issue;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    skid_full_d   = skid_full_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    misalign_d    = misalign_q;

    issue = (state_q == RUN) && bus.fetch_en && !skid_full_q &&
            (!inflight_q || bus.out_ready) && !bus.redirect_valid;

    inflight_d = issue;
    if (issue) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_WIDTH'(4);
    end

    // Park the returning word when decode stalls; the skid drains with a bubble.
    if (inflight_q && !bus.out_ready && !skid_full_q) begin
      skid_full_d = 1'b1;
      skid_inst_d = bus.imem_inst;
      skid_pc_d   = inflight_pc_q;
    end else if (skid_full_q && bus.out_ready) begin
      skid_full_d = 1'b0;
    end

    case (state_q)
      IDLE:    if (bus.fetch_en) state_d = RUN;
      RUN:     if (!bus.fetch_en) state_d = IDLE;
               else if (inflight_q && !bus.out_ready) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Redirect wins over everything: drop the in-flight word and the skid.
    if (bus.redirect_valid) begin
      pc_d        = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inflight_d  = 1'b0;
      skid_full_d = 1'b0;
      state_d     = bus.fetch_en ? RUN : IDLE;
      if (bus.redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      skid_full_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      skid_full_q <= skid_full_d;
      misalign_q  <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    skid_inst_q   <= skid_inst_d;
    skid_pc_q     <= skid_pc_d;
  end

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = !bus.redirect_valid && (skid_full_q || inflight_q);
  assign bus.out_inst     = skid_full_q ? skid_inst_q : bus.imem_inst;
  assign bus.out_pc       = skid_full_q ? skid_pc_q : inflight_pc_q;
  assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized bench for inst_fetch_ctrl: an in-order PC-stream scoreboard plus
// cycle-level protocol checks (squash, latency, throughput, stall stability).
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [AW-1:0] RST_PC = '0;

  logic clk, rst;
  inst_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  inst_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [63:0] h;
    h = 64'(a) * 64'h9E37_79B1 ^ 64'h5A5A_0F0F;
    return DW'(h);
  endfunction

  // Instruction memory: registered read, one cycle after the address.
  always @(posedge clk) bus.imem_inst <= mem_word(bus.imem_addr);

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode must see one contiguous PC stream that restarts at the
  // reset PC or at an aligned redirect target; unaccepted words are dropped.
  logic [AW-1:0]   exp_q[$];
  longint unsigned next_pc;

  task automatic drive(input logic r, fe, ordy, rv, input logic [AW-1:0] rpc);
    rst = r; bus.fetch_en = fe; bus.out_ready = ordy;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
    if (r) begin
      exp_q.delete(); next_pc = longint'(RST_PC);
    end else if (rv) begin
      exp_q.delete(); next_pc = longint'(rpc) - (longint'(rpc) % 4);
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(AW'(next_pc));
      next_pc = (next_pc + 4) % (64'd1 << AW);
    end
  endtask

  task automatic step(input logic r, fe, ordy, rv, input logic [AW-1:0] rpc);
    @(posedge clk); #1;
    drive(r, fe, ordy, rv, rpc);
  endtask

  task automatic run(input int n, input logic fe, ordy);
    repeat (n) step(1'b0, fe, ordy, 1'b0, '0);
  endtask

  // Monitor history
  logic          started = 1'b0, exp_mis = 1'b0;
  logic          p_rst, p_rv, p_fe, p2_rst, p2_rv, p2_fe, p_stall;
  logic [AW-1:0] p_rpc, p2_rpc, p_pc, exp_pc;
  logic [DW-1:0] p_inst;
  int            run_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      if (p_rst) chk("valid_after_reset", 64'(bus.out_valid), 64'd0);
      if (bus.redirect_valid) chk("valid_on_redirect", 64'(bus.out_valid), 64'd0);
      if (p_rv) chk("valid_after_redirect", 64'(bus.out_valid), 64'd0);
      if (p2_rv && p2_fe && !p2_rst && !p_rv && !p_rst && p_fe && !bus.redirect_valid) begin
        chk("redirect_latency_valid", 64'(bus.out_valid), 64'd1);
        chk("redirect_latency_pc", 64'(bus.out_pc), 64'({p2_rpc[AW-1:2], 2'b00}));
      end
      run_cnt = (bus.fetch_en && bus.out_ready && !bus.redirect_valid && !rst) ? run_cnt + 1 : 0;
      if (run_cnt >= 3) chk("throughput_valid", 64'(bus.out_valid), 64'd1);
      if (p_stall && !p_rst && !bus.redirect_valid) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_pc", 64'(bus.out_pc), 64'(p_pc));
        chk("stall_inst", 64'(bus.out_inst), 64'(p_inst));
      end
      chk("misalign_err", 64'(bus.misalign_err), 64'(exp_mis));
      if (bus.out_valid && bus.out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer_pc", 64'(bus.out_pc), 64'hDEAD_0000_0000_0000);
        end else begin
          exp_pc = exp_q.pop_front();
          chk("stream_pc", 64'(bus.out_pc), 64'(exp_pc));
          chk("stream_inst", 64'(bus.out_inst), 64'(mem_word(exp_pc)));
        end
      end
    end
    if (rst) exp_mis = 1'b0;
    else if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
    if (rst) started = 1'b1;
    p2_rst = p_rst; p2_rv = p_rv; p2_fe = p_fe; p2_rpc = p_rpc;
    p_rst = rst; p_rv = bus.redirect_valid; p_fe = bus.fetch_en; p_rpc = bus.redirect_pc;
    p_stall = bus.out_valid && !bus.out_ready && !rst;
    p_pc = bus.out_pc; p_inst = bus.out_inst;
  end

  initial begin
    logic          r, fe, ordy, rv;
    logic [AW-1:0] rpc;
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    // Straight-line stream from reset, then a 3-cycle decode stall.
    run(10, 1'b1, 1'b1);
    run(3, 1'b1, 1'b0);
    run(6, 1'b1, 1'b1);
    // Aligned and misaligned redirects while streaming.
    step(1'b0, 1'b1, 1'b1, 1'b1, AW'(32'h40));
    run(6, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, AW'(32'h42));
    run(6, 1'b1, 1'b1);
    // fetch_en drop with a pending word, then resume.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    run(3, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);
    // Clear the sticky flag, then wrap the PC through the top of the space.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    run(2, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, {AW{1'b1}} - AW'(7));
    run(8, 1'b1, 1'b1);
    // Reset while the skid holds a word.
    run(2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    run(8, 1'b1, 1'b1);
    // Random traffic.
    repeat (2000) begin
      r    = ($urandom_range(0, 149) == 0);
      fe   = ($urandom_range(0, 7) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      rv   = !r && ($urandom_range(0, 19) == 0);
      rpc  = AW'($urandom) & AW'(32'hFFC);
      if ($urandom_range(0, 7) == 0) rpc = {AW{1'b1}} - AW'(15) + (rpc & AW'(12));
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(r, fe, ordy, rv, rpc);
    end
    run(4, 1'b1, 1'b1);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
